// File: rtl/dump_sequencer.sv
// dump_sequencer: steps a read address through data memory or the register file and latches the value for display.
// Define DUMP_AUTO_SCAN_EN to add a dwell counter that auto-advances after DWELL SHOW cycles.
module dump_sequencer #(
  parameter int unsigned DWELL = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add,
  input  logic        select,
  input  logic [15:0] memData,
  input  logic [15:0] grData,
  output logic [7:0]  address,
  output logic [15:0] data,
  output logic        displayEnable
);
  typedef enum logic [1:0] {FETCH, LATCH, SHOW} state_e;
  state_e state_q, state_d;
  logic sel_q, sel_chg, step, capture, de_d;
  logic [7:0] addr_d;
  logic [15:0] data_d;
  if (DWELL == 0 || DWELL > 16777215) begin : g_dwell_chk
    $error("DWELL out of range");
  end
  assign sel_chg = select != sel_q;
  assign capture = !sel_chg && state_q != FETCH;
`ifdef DUMP_AUTO_SCAN_EN
  localparam logic [23:0] LAST = 24'(DWELL - 1);
  logic [23:0] dwell_q, dwell_d;
  // a select change wins over any advance, so the counter is gated by it too
  assign step = !sel_chg && state_q == SHOW && (add || dwell_q == LAST);
  always_comb dwell_d = (state_q == SHOW && !sel_chg && !step) ? dwell_q + 24'd1 : 24'd0;
  always_ff @(posedge clk) dwell_q <= reset ? 24'd0 : dwell_d;
`else
  assign step = !sel_chg && state_q == SHOW && add;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      sel_q         <= select;
      address       <= 8'd0;
      data          <= 16'h0000;
      displayEnable <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= select;
      address       <= addr_d;
      data          <= data_d;
      displayEnable <= de_d;
    end
  end
  always_comb state_d = (sel_chg || step) ? FETCH : (state_q == FETCH) ? LATCH : SHOW;
  always_comb begin
    addr_d = sel_chg ? 8'd0 : step ? (sel_q ? {5'd0, address[2:0] + 3'd1} : address + 8'd1) : address;
    data_d = capture ? (sel_q ? grData : memData) : data;
    de_d   = displayEnable | capture;
  end
endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer: table vectors, directed corner sequences and random stimulus against a phase-level model.
module tb_dump_sequencer;
  localparam int unsigned TB_DWELL = 4;
`ifdef DUMP_AUTO_SCAN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1, add = 1'b0, select = 1'b0;
  logic [15:0] mem [256];
  logic [15:0] gr [8];
  logic [15:0] memData, grData, data;
  logic [7:0] address;
  logic displayEnable;
  int checks = 0, errors = 0;
  logic [7:0] m_addr;
  logic [15:0] m_data;
  logic m_de, m_sel;
  int m_phase, m_dw;

  always #5 clk = ~clk;
  assign memData = mem[address];
  assign grData  = gr[address[2:0]];

  dump_sequencer #(.DWELL(TB_DWELL)) dut (
    .clk(clk), .reset(reset), .add(add), .select(select),
    .memData(memData), .grData(grData),
    .address(address), .data(data), .displayEnable(displayEnable)
  );

  typedef struct packed {
    logic r, a, s;
    logic [7:0] ea;
    logic [15:0] ed;
    logic ee;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // phase 0 = waiting for address to settle, 1 = capture next, 2 = showing live data
  task automatic model_edge();
    bit adv;
    if (reset) begin
      m_addr = 0; m_data = 0; m_de = 0; m_sel = select; m_phase = 0; m_dw = 0;
    end else if (select != m_sel) begin
      m_sel = select; m_addr = 0; m_phase = 0; m_dw = 0;
    end else begin
      adv = m_phase == 2 && (add || (AUTO && m_dw == TB_DWELL - 1));
      if (m_phase >= 1) begin
        m_data = m_sel ? gr[m_addr[2:0]] : mem[m_addr];
        m_de = 1;
      end
      if (adv) begin
        m_addr = m_sel ? 8'((m_addr + 1) % 8) : 8'((m_addr + 1) % 256);
        m_phase = 0; m_dw = 0;
      end else begin
        if (m_phase == 2) m_dw++;
        m_phase = (m_phase < 2) ? m_phase + 1 : 2;
      end
    end
  endtask

  task automatic step(input logic r, input logic a, input logic s);
    reset = r; add = a; select = s;
    model_edge();
    @(posedge clk);
    #1;
    chk("model_addr", 32'(address), 32'(m_addr));
    chk("model_data", 32'(data), 32'(m_data));
    chk("model_de", 32'(displayEnable), 32'(m_de));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, s);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) gr[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'hABCD; gr[0] = 16'h0F0F; gr[1] = 16'h1111;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 16'h1234, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd1, 16'h1234, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd1, 16'h1234, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'd1, 16'hABCD, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd1, 16'hABCD, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'd0, 16'hABCD, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'd0, 16'hABCD, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'd0, 16'h0F0F, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'd1, 16'h0F0F, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'd1, 16'h0F0F, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'd1, 16'h1111, 1'b1};
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].s);
      chk($sformatf("tbl_addr[%0d]", i), 32'(address), 32'(tbl[i].ea));
      chk($sformatf("tbl_data[%0d]", i), 32'(data), 32'(tbl[i].ed));
      chk($sformatf("tbl_de[%0d]", i), 32'(displayEnable), 32'(tbl[i].ee));
    end
    // register view wraps 7 -> 0 with the upper address bits held at zero
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk($sformatf("gr_walk[%0d]", k), 32'(address), 32'(k % 8));
      idle(4, 1'b1);
    end
    // memory view climbs to 255, wraps, and ignores an add in FETCH
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int k = 0; k < 255; k++) begin
      step(1'b0, 1'b1, 1'b0);
      idle(4, 1'b0);
    end
    chk("mem_at_255", 32'(address), 32'd255);
    step(1'b0, 1'b1, 1'b0);
    chk("mem_wrap", 32'(address), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("fetch_add_dropped", 32'(address), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_capture", 32'(data), 32'h1234);
    mem[0] = 16'hBEEF;
    step(1'b0, 1'b0, 1'b0);
    chk("live_follow", 32'(data), 32'hBEEF);
    step(1'b0, 1'b1, 1'b1);
    chk("sel_and_add_addr", 32'(address), 32'd0);
    idle(2, 1'b1);
    chk("sel_and_add_data", 32'(data), 32'h0F0F);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
`ifdef DUMP_AUTO_SCAN_EN
    for (int k = 1; k <= 2; k++) begin
      idle(6, 1'b0);
      chk($sformatf("auto_adv[%0d]", k), 32'(address), 32'(k));
    end
    idle(3, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("auto_reset_addr", 32'(address), 32'd0);
    idle(5, 1'b0);
    chk("auto_restart_hold", 32'(address), 32'd0);
    idle(1, 1'b0);
    chk("auto_restart_adv", 32'(address), 32'd1);
`else
    idle(50, 1'b0);
    mem[0] = 16'h5A5A;
    idle(50, 1'b0);
    chk("noauto_addr", 32'(address), 32'd0);
    chk("noauto_data", 32'(data), 32'h5A5A);
`endif
    for (int i = 0; i < 400; i++) begin
      logic r, a, s;
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 255)] = 16'($urandom);
      if ($urandom_range(0, 9) == 0) gr[$urandom_range(0, 7)] = 16'($urandom);
      r = $urandom_range(0, 59) == 0;
      a = $urandom_range(0, 3) == 0;
      s = ($urandom_range(0, 24) == 0) ? ~select : select;
      step(r, a, s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
